// File: rtl/stepper_move_scheduler_if.sv
// Command/pin bundle for the two-axis stepper move scheduler.
// The master side is the command source; the slave side is the scheduler.
interface stepper_move_scheduler_if #(
  parameter int CNT_W = 16,
  parameter int POS_W = 32
);
  logic                    step_tick;
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic signed [CNT_W-1:0] cmd_dx;
  logic signed [CNT_W-1:0] cmd_dy;
  logic                    abort;
  logic                    step_x, step_y;
  logic                    dir_x, dir_y;
  logic                    busy, done, aborted;
  logic signed [POS_W-1:0] pos_x, pos_y;

  modport master (
    output step_tick, cmd_valid, cmd_dx, cmd_dy, abort,
    input  cmd_ready, step_x, step_y, dir_x, dir_y, busy, done, aborted, pos_x, pos_y
  );

  modport slave (
    input  step_tick, cmd_valid, cmd_dx, cmd_dy, abort,
    output cmd_ready, step_x, step_y, dir_x, dir_y, busy, done, aborted, pos_x, pos_y
  );
endinterface

// File: rtl/stepper_move_scheduler.sv
// Two-axis linear-move sequencer: Bresenham interleave of X/Y step pulses,
// one major-axis step per step_tick, with direction setup and position tracking.
module stepper_move_scheduler #(
  parameter int CNT_W        = 16,
  parameter int POS_W        = 32,
  parameter int PULSE_CYCLES = 200,
  parameter int DIR_SETUP    = 100
) (
  input  logic                      clk_100mhz,
  input  logic                      rst,
  stepper_move_scheduler_if.slave   bus
);
  localparam int CMAX = (PULSE_CYCLES > DIR_SETUP) ? PULSE_CYCLES : DIR_SETUP;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, SETUP, WAIT_TICK, PULSE, DONE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] ax_q, ay_q, n_q, rem_q;
  logic [CNT_W:0]   acc_x_q, acc_y_q;
  logic [CW-1:0]    cnt_q;
  logic             dir_x_q, dir_y_q, step_x_q, step_y_q;
  logic             aborted_q, abort_pend_q;
  logic [POS_W-1:0] pos_x_q, pos_y_q;

  logic [CNT_W-1:0] ax_d, ay_d, n_d;
  logic [CNT_W:0]   sum_x, sum_y;
  logic             hit_x, hit_y;

  // Magnitudes are CNT_W-bit unsigned, so the most negative delta maps cleanly.
  always_comb begin
    ax_d  = bus.cmd_dx[CNT_W-1] ? (~bus.cmd_dx + 1'b1) : bus.cmd_dx;
    ay_d  = bus.cmd_dy[CNT_W-1] ? (~bus.cmd_dy + 1'b1) : bus.cmd_dy;
    n_d   = (ax_d >= ay_d) ? ax_d : ay_d;
    sum_x = acc_x_q + {1'b0, ax_q};
    sum_y = acc_y_q + {1'b0, ay_q};
    hit_x = (sum_x >= {1'b0, n_q});
    hit_y = (sum_y >= {1'b0, n_q});
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state_q      <= IDLE;
      ax_q         <= '0;
      ay_q         <= '0;
      n_q          <= '0;
      rem_q        <= '0;
      acc_x_q      <= '0;
      acc_y_q      <= '0;
      cnt_q        <= '0;
      dir_x_q      <= 1'b0;
      dir_y_q      <= 1'b0;
      step_x_q     <= 1'b0;
      step_y_q     <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      pos_x_q      <= '0;
      pos_y_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.cmd_valid) begin
          ax_q         <= ax_d;
          ay_q         <= ay_d;
          n_q          <= n_d;
          rem_q        <= n_d;
          acc_x_q      <= {1'b0, n_d >> 1};
          acc_y_q      <= {1'b0, n_d >> 1};
          dir_x_q      <= ~bus.cmd_dx[CNT_W-1];
          dir_y_q      <= ~bus.cmd_dy[CNT_W-1];
          aborted_q    <= 1'b0;
          abort_pend_q <= 1'b0;
          cnt_q        <= CW'(DIR_SETUP);
          state_q      <= (n_d == '0) ? DONE : SETUP;
        end
        SETUP: begin
          if (bus.abort) begin
            aborted_q <= 1'b1;
            state_q   <= DONE;
          end else if (cnt_q <= CW'(1)) begin
            state_q <= WAIT_TICK;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        WAIT_TICK: begin
          if (bus.abort) begin
            aborted_q <= 1'b1;
            state_q   <= DONE;
          end else if (bus.step_tick) begin
            step_x_q <= hit_x;
            step_y_q <= hit_y;
            acc_x_q  <= hit_x ? (sum_x - {1'b0, n_q}) : sum_x;
            acc_y_q  <= hit_y ? (sum_y - {1'b0, n_q}) : sum_y;
            // +1 when dir is set, all-ones (-1) otherwise
            if (hit_x) pos_x_q <= pos_x_q + {{(POS_W-1){~dir_x_q}}, 1'b1};
            if (hit_y) pos_y_q <= pos_y_q + {{(POS_W-1){~dir_y_q}}, 1'b1};
            rem_q    <= rem_q - 1'b1;
            cnt_q    <= CW'(PULSE_CYCLES);
            state_q  <= PULSE;
          end
        end
        PULSE: begin
          // An abort here is remembered so the pulse always runs full width.
          if (bus.abort) abort_pend_q <= 1'b1;
          if (cnt_q <= CW'(1)) begin
            step_x_q <= 1'b0;
            step_y_q <= 1'b0;
            if (abort_pend_q || bus.abort) begin
              aborted_q <= 1'b1;
              state_q   <= DONE;
            end else if (rem_q == '0) begin
              state_q <= DONE;
            end else begin
              state_q <= WAIT_TICK;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.aborted   = aborted_q;
  assign bus.step_x    = step_x_q;
  assign bus.step_y    = step_y_q;
  assign bus.dir_x     = dir_x_q;
  assign bus.dir_y     = dir_y_q;
  assign bus.pos_x     = pos_x_q;
  assign bus.pos_y     = pos_y_q;
endmodule
